expander_mailbox: RTL and testbench
===================================

// Module: expander_mailbox
// PURPOSE
//  Slave peripheral hung off the bus expander's decoded register strobes: two expander register slots.
//  Slot DATA: CPU writes push the TX FIFO; CPU reads pop the RX FIFO.
//  Slot STATUS: reads return occupancy and sticky error flags; writes clear flags and set control.
//  Hardware side: valid/ready stream out of TX and into RX, e.g. for a UART or SPI engine.
// PARAMETERS
//  DEPTH_LOG2   4   log2 of each FIFO depth; legal 1..5 (depth 2..32 words of 16 bits)
// PORTS
//  sysclk        in   1   system clock, all logic on rising edge
//  sysreset      in   1   synchronous, active-high reset
//  load_data     in   16  expander write data (r_load_data)
//  data_load     in   1   DATA slot write strobe (r_load[DATA])
//  data_read     in   1   DATA slot read strobe (r_read[DATA])
//  data_out      out  16  DATA slot read value (to r[DATA])
//  status_load   in   1   STATUS slot write strobe
//  status_read   in   1   STATUS slot read strobe (no side effect)
//  status_out    out  16  STATUS slot read value
//  tx_data       out  16  TX FIFO head word
//  tx_valid      out  1   TX FIFO non-empty
//  tx_ready      in   1   consumer accepts tx_data when tx_valid & tx_ready
//  rx_data       in   16  producer word
//  rx_valid      in   1   producer offers rx_data
//  rx_ready      out  1   = RX FIFO not full; word taken when rx_valid & rx_ready
// BEHAVIOUR
//  - FIFOs: circular buffers, DEPTH_LOG2-bit pointers wrapping at depth. Count is DEPTH_LOG2+1 bits, 0..depth.
//  - FIFO storage is not reset. Pointers, counts, flags and control bits reset to 0.
//  - Reset outputs: data_out=0, status_out=0, tx_valid=0, tx_data=don't-care, rx_ready=1.
//  - Reset mid-operation: the same edge discards all FIFO contents and flags; any same-cycle strobe is ignored.
//  - Expander read timing: the strobe arrives in the cycle the expander captures r[].
//  - data_out is therefore combinational show-ahead: RX head when non-empty, else 16'h0000.
//  - Pop occurs on the same edge as the capture; read latency to expander is zero cycles.
//  - data_load & TX not full (sampled start of cycle) -> push load_data; new word visible on tx_data next cycle.
//  - data_load & TX full -> word dropped, tx_overflow<=1; an HW pop in the same cycle does not make room.
//  - data_read & RX empty -> returns 0, rx_underflow<=1, pointers unchanged.
//  - RX push happens only via the handshake; rx_ready=0 when full, so producer overflow cannot occur.
//  - Simultaneous push+pop on a non-full, non-empty FIFO: both happen, count unchanged.
//  - Simultaneous push+pop on an empty FIFO: pop not possible (valid/ready or underflow rule); push only.
//  - status_out: [15] rx_underflow, [14] tx_overflow, [13] tx_empty, [12] irq_en, [11:6] tx_count, [5:0] rx_count.
//  - Counts are zero-extended to 6 bits. status_out is combinational from registered state.
//  - status_load: load_data[15]=1 clears rx_underflow; [14]=1 clears tx_overflow (write-1-to-clear).
//  - status_load: load_data[12] -> irq_en. Other bits are ignored.
//  - A set event and a clear in the same cycle: set wins.
// CONFIGURATION
//  EXPANDER_MAILBOX_IRQ_EN defined:
//   - adds output irq (1 bit, registered, reset 0).
//   - irq <= irq_en & (rx_count!=0 | tx_overflow | rx_underflow); one-cycle latency from state.
//  EXPANDER_MAILBOX_IRQ_EN undefined:
//   - no irq port; status bit 12 reads 0 and writes to it are ignored.
// TESTING
//  Reset, idle: status_out=16'h2000 (tx_empty), data_out=0, tx_valid=0, rx_ready=1.
//  DEPTH_LOG2=4, tx_ready=0; write 0x1111..0x1110+16, then one more write:
//   -> tx_count=16, tx_overflow=1, tx_data=0x1111.
//   Then tx_ready=1 for 16 cycles -> words out in order, tx_valid falls.
//  Drive rx_valid with 0xA5A5 then 0x5A5A; two data_read strobes:
//   -> data_out=0xA5A5 then 0x5A5A on the strobe cycles, rx_count 2->1->0.
//   A third strobe -> data_out=0, status[15]=1.
//  Write STATUS 0xC000 with rx_underflow and tx_overflow set -> both clear next cycle.
//   Same test with a data_read on an empty FIFO in the same cycle -> rx_underflow stays 1.
//  TX at depth-1, data_load and HW pop same cycle -> count unchanged, order intact.
//   Repeat with TX full -> write dropped, tx_overflow=1, count depth-1.
//  Fill both FIFOs half, assert sysreset one cycle with strobes active -> all counts 0, flags 0, rx_ready=1.
//  IRQ_EN build: write STATUS 0x1000, push one RX word -> irq=1 one cycle later; pop it -> irq=0 one cycle later.

Source files
------------

// File: rtl/expander_mailbox.sv
// expander_mailbox
//   Two-slot mailbox peripheral on the bus expander's decoded register strobes.
//   DATA slot   : writes push the TX FIFO, reads pop the RX FIFO (zero-latency
//                 show-ahead read value on data_out).
//   STATUS slot : reads return flags and occupancy; writes clear sticky flags
//                 (write-1-to-clear) and set the interrupt enable.
//   Hardware side is a valid/ready stream out of TX and into RX.
//
// Parameters
//   DEPTH_LOG2   log2 of each FIFO depth (1..5)
//
// Ports
//   sysclk, sysreset              clock, synchronous active-high reset
//   load_data[15:0]               expander write data
//   data_load, data_read          DATA slot write / read strobes
//   data_out[15:0]                DATA slot read value (RX head or 0)
//   status_load, status_read      STATUS slot write / read strobes
//   status_out[15:0]              {rx_underflow, tx_overflow, tx_empty, irq_en,
//                                  tx_count[5:0], rx_count[5:0]}
//   tx_data, tx_valid, tx_ready   TX stream (head word out)
//   rx_data, rx_valid, rx_ready   RX stream (producer in)
//   irq                           interrupt, only when EXPANDER_MAILBOX_IRQ_EN
//
// Build option
//   EXPANDER_MAILBOX_IRQ_EN : adds the registered irq output and the irq_en
//                             control bit; otherwise status bit 12 reads 0.
module expander_mailbox #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        sysclk,
  input  logic        sysreset,
  input  logic [15:0] load_data,
  input  logic        data_load,
  input  logic        data_read,
  output logic [15:0] data_out,
  input  logic        status_load,
  input  logic        status_read,
  output logic [15:0] status_out,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
`ifdef EXPANDER_MAILBOX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [DEPTH_LOG2-1:0] ONE_PTR = DEPTH_LOG2'(1);

  logic [15:0]           tx_mem_r [DEPTH];
  logic [15:0]           rx_mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wr_ptr_r, tx_rd_ptr_r, rx_wr_ptr_r, rx_rd_ptr_r;
  logic [CNT_W-1:0]      tx_count_r, rx_count_r;
  logic                  tx_overflow_r, rx_underflow_r;
  logic                  irq_en_s;
  logic                  tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic                  tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;

  // Reads of STATUS have no side effect.
  logic unused_status_read_s;
  assign unused_status_read_s = status_read;

  // FIFO occupancy decode and push/pop qualification from start-of-cycle state.
  always_comb begin
    tx_full_s  = (tx_count_r == FULL_CNT);
    tx_empty_s = (tx_count_r == ZERO_CNT);
    rx_full_s  = (rx_count_r == FULL_CNT);
    rx_empty_s = (rx_count_r == ZERO_CNT);
    // A full TX rejects the write even if the consumer pops on the same edge.
    tx_push_s  = data_load & ~tx_full_s;
    tx_pop_s   = tx_ready & ~tx_empty_s;
    rx_push_s  = rx_valid & ~rx_full_s;
    rx_pop_s   = data_read & ~rx_empty_s;
  end

  // FIFO storage writes; contents are deliberately not reset.
  always_ff @(posedge sysclk) begin
    if (!sysreset && tx_push_s) begin
      tx_mem_r[tx_wr_ptr_r] <= load_data;
    end
    if (!sysreset && rx_push_s) begin
      rx_mem_r[rx_wr_ptr_r] <= rx_data;
    end
  end

  // TX pointers and count.
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      tx_wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      tx_rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      tx_count_r  <= ZERO_CNT;
    end else begin
      if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + ONE_PTR;
      if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + ONE_PTR;
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_count_r <= tx_count_r + ONE_CNT;
        2'b01:   tx_count_r <= tx_count_r - ONE_CNT;
        default: tx_count_r <= tx_count_r;
      endcase
    end
  end

  // RX pointers and count.
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      rx_wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rx_rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      rx_count_r  <= ZERO_CNT;
    end else begin
      if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + ONE_PTR;
      if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + ONE_PTR;
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_count_r <= rx_count_r + ONE_CNT;
        2'b01:   rx_count_r <= rx_count_r - ONE_CNT;
        default: rx_count_r <= rx_count_r;
      endcase
    end
  end

  // Sticky error flags; a set event outranks a same-cycle clear.
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      tx_overflow_r  <= 1'b0;
      rx_underflow_r <= 1'b0;
    end else begin
      if (data_load && tx_full_s) begin
        tx_overflow_r <= 1'b1;
      end else if (status_load && load_data[14]) begin
        tx_overflow_r <= 1'b0;
      end else begin
        tx_overflow_r <= tx_overflow_r;
      end
      if (data_read && rx_empty_s) begin
        rx_underflow_r <= 1'b1;
      end else if (status_load && load_data[15]) begin
        rx_underflow_r <= 1'b0;
      end else begin
        rx_underflow_r <= rx_underflow_r;
      end
    end
  end

`ifdef EXPANDER_MAILBOX_IRQ_EN
  logic irq_en_r;
  logic irq_r;

  // Interrupt enable control bit and registered interrupt output.
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      irq_en_r <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      if (status_load) begin
        irq_en_r <= load_data[12];
      end else begin
        irq_en_r <= irq_en_r;
      end
      irq_r <= irq_en_r & (~rx_empty_s | tx_overflow_r | rx_underflow_r);
    end
  end

  assign irq_en_s = irq_en_r;
  assign irq      = irq_r;
`else
  assign irq_en_s = 1'b0;
`endif

  // Expander-facing read values and stream handshakes. data_out must be
  // combinational: the expander captures it on the same edge that pops.
  always_comb begin
    data_out   = rx_empty_s ? 16'h0000 : rx_mem_r[rx_rd_ptr_r];
    tx_data    = tx_mem_r[tx_rd_ptr_r];
    tx_valid   = ~tx_empty_s;
    rx_ready   = ~rx_full_s;
    status_out = {rx_underflow_r, tx_overflow_r, tx_empty_s, irq_en_s,
                  6'(tx_count_r), 6'(rx_count_r)};
  end

endmodule

// File: tb/tb_expander_mailbox.sv
module tb_expander_mailbox;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic        sysclk;
  logic        sysreset;
  logic [15:0] load_data;
  logic        data_load, data_read, status_load, status_read;
  logic [15:0] data_out, status_out, tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
`ifdef EXPANDER_MAILBOX_IRQ_EN
  logic        irq;
`endif

  expander_mailbox #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .sysclk      (sysclk),
    .sysreset    (sysreset),
    .load_data   (load_data),
    .data_load   (data_load),
    .data_read   (data_read),
    .data_out    (data_out),
    .status_load (status_load),
    .status_read (status_read),
    .status_out  (status_out),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready)
`ifdef EXPANDER_MAILBOX_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain queues and flags.
  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  bit ovf_m, und_m, irq_en_m, irq_m;
  bit model_ok = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_status();
    return {und_m, ovf_m, (tx_q.size() == 0), irq_en_m, 6'(tx_q.size()), 6'(rx_q.size())};
  endfunction

  task automatic model_step();
    bit tx_full, tx_pop, tx_push, rx_empty, rx_push;
    if (sysreset) begin
      tx_q.delete();
      rx_q.delete();
      ovf_m = 1'b0; und_m = 1'b0; irq_en_m = 1'b0; irq_m = 1'b0;
    end else begin
      irq_m    = irq_en_m && (rx_q.size() != 0 || ovf_m || und_m);
      tx_full  = (tx_q.size() == DEPTH);
      tx_pop   = (tx_q.size() != 0) && tx_ready;
      tx_push  = data_load && !tx_full;
      if (tx_pop)  void'(tx_q.pop_front());
      if (tx_push) tx_q.push_back(load_data);
      if (data_load && tx_full) ovf_m = 1'b1;
      else if (status_load && load_data[14]) ovf_m = 1'b0;
      rx_empty = (rx_q.size() == 0);
      rx_push  = rx_valid && (rx_q.size() < DEPTH);
      if (data_read && !rx_empty) void'(rx_q.pop_front());
      if (rx_push) rx_q.push_back(rx_data);
      if (data_read && rx_empty) und_m = 1'b1;
      else if (status_load && load_data[15]) und_m = 1'b0;
`ifdef EXPANDER_MAILBOX_IRQ_EN
      if (status_load) irq_en_m = load_data[12];
`endif
    end
  endtask

  // Compare all outputs against the model, then advance one clock.
  task automatic tick();
    #1;
    if (model_ok) begin
      check_eq("data_out", 32'(data_out), 32'((rx_q.size() != 0) ? rx_q[0] : 16'h0000));
      check_eq("status_out", 32'(status_out), 32'(exp_status()));
      check_eq("tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
      check_eq("rx_ready", 32'(rx_ready), 32'(rx_q.size() < DEPTH));
      if (tx_q.size() != 0) check_eq("tx_data", 32'(tx_data), 32'(tx_q[0]));
`ifdef EXPANDER_MAILBOX_IRQ_EN
      check_eq("irq", 32'(irq), 32'(irq_m));
`endif
    end
    @(posedge sysclk);
    model_step();
    model_ok = 1'b1;
    @(negedge sysclk);
  endtask

  task automatic idle_inputs();
    data_load = 1'b0; data_read = 1'b0; status_load = 1'b0; status_read = 1'b0;
    rx_valid = 1'b0; tx_ready = 1'b0; sysreset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    load_data = 16'h0000; rx_data = 16'h0000;
    sysreset = 1'b1;
    tick(); tick();
    sysreset = 1'b0;
    tick();
    check_eq("rst_status", 32'(status_out), 32'h0000_2000);
    check_eq("rst_data_out", 32'(data_out), 32'h0);
    check_eq("rst_tx_valid", 32'(tx_valid), 32'h0);
    check_eq("rst_rx_ready", 32'(rx_ready), 32'h1);

    // Fill TX past full with the consumer stalled.
    for (int i = 0; i < 17; i++) begin
      data_load = 1'b1; load_data = 16'(32'h1111 + i);
      tick();
    end
    data_load = 1'b0;
    check_eq("tx_cnt_full", 32'(status_out[11:6]), 32'd16);
    check_eq("tx_ovf_set", 32'(status_out[14]), 32'd1);
    check_eq("tx_head", 32'(tx_data), 32'h1111);

    // Drain.
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    tx_ready = 1'b0;
    check_eq("tx_drained", 32'(tx_valid), 32'd0);

    // RX two words then three reads.
    rx_valid = 1'b1; rx_data = 16'hA5A5; tick();
    rx_data = 16'h5A5A; tick();
    rx_valid = 1'b0;
    data_read = 1'b1;
    #1;
    check_eq("rx_rd0", 32'(data_out), 32'hA5A5);
    check_eq("rx_cnt2", 32'(status_out[5:0]), 32'd2);
    tick();
    check_eq("rx_rd1", 32'(data_out), 32'h5A5A);
    check_eq("rx_cnt1", 32'(status_out[5:0]), 32'd1);
    tick();
    check_eq("rx_rd2", 32'(data_out), 32'h0);
    check_eq("rx_cnt0", 32'(status_out[5:0]), 32'd0);
    tick();
    data_read = 1'b0;
    check_eq("rx_und_set", 32'(status_out[15]), 32'd1);

    // Write-1-to-clear, then set-wins-over-clear.
    status_load = 1'b1; load_data = 16'hC000; tick();
    status_load = 1'b0;
    check_eq("flags_clr", 32'(status_out[15:14]), 32'd0);
    data_read = 1'b1; tick();
    status_load = 1'b1; load_data = 16'hC000; tick();
    data_read = 1'b0; status_load = 1'b0;
    check_eq("und_set_wins", 32'(status_out[15]), 32'd1);

    // TX at depth-1 with simultaneous write and pop.
    for (int i = 0; i < DEPTH - 1; i++) begin
      data_load = 1'b1; load_data = 16'(32'h2000 + i); tick();
    end
    tx_ready = 1'b1; load_data = 16'h20FF; tick();
    tx_ready = 1'b0;
    check_eq("tx_cnt_dm1", 32'(status_out[11:6]), 32'(DEPTH - 1));
    load_data = 16'h2100; tick();
    tx_ready = 1'b1; load_data = 16'h2200; tick();
    data_load = 1'b0; tx_ready = 1'b0;
    check_eq("tx_full_drop_cnt", 32'(status_out[11:6]), 32'(DEPTH - 1));
    check_eq("tx_full_drop_ovf", 32'(status_out[14]), 32'd1);
    tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    tx_ready = 1'b0;

    // Half fill both, then reset with strobes active.
    for (int i = 0; i < DEPTH / 2; i++) begin
      data_load = 1'b1; load_data = 16'(32'h3000 + i);
      rx_valid = 1'b1; rx_data = 16'(32'h4000 + i);
      tick();
    end
    sysreset = 1'b1; data_read = 1'b1; status_load = 1'b1; load_data = 16'h1000;
    tick();
    idle_inputs();
    check_eq("mid_rst_status", 32'(status_out), 32'h0000_2000);
    check_eq("mid_rst_rx_ready", 32'(rx_ready), 32'h1);
    check_eq("mid_rst_data_out", 32'(data_out), 32'h0);

`ifdef EXPANDER_MAILBOX_IRQ_EN
    status_load = 1'b1; load_data = 16'h1000; tick();
    status_load = 1'b0;
    rx_valid = 1'b1; rx_data = 16'h00AA; tick();
    rx_valid = 1'b0;
    tick();
    check_eq("irq_rise", 32'(irq), 32'd1);
    data_read = 1'b1; tick();
    data_read = 1'b0;
    tick();
    check_eq("irq_fall", 32'(irq), 32'd0);
`endif

    // Randomized traffic with varying consumer/producer pressure.
    for (int blk = 0; blk < 10; blk++) begin
      int tx_p, rx_p, rd_p, wr_p;
      tx_p = int'($urandom_range(0, 4));
      rx_p = int'($urandom_range(0, 4));
      rd_p = int'($urandom_range(0, 4));
      wr_p = int'($urandom_range(0, 4));
      for (int c = 0; c < 200; c++) begin
        sysreset    = ($urandom_range(0, 299) == 0);
        data_load   = (int'($urandom_range(0, 4)) < wr_p);
        data_read   = (int'($urandom_range(0, 4)) < rd_p);
        tx_ready    = (int'($urandom_range(0, 4)) < tx_p);
        rx_valid    = (int'($urandom_range(0, 4)) < rx_p);
        status_load = ($urandom_range(0, 15) == 0);
        status_read = ($urandom_range(0, 3) == 0);
        load_data   = 16'($urandom);
        rx_data     = 16'($urandom);
        tick();
      end
    end
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
